// File: rtl/fb_mem_arbiter.sv
// Framebuffer memory arbiter: display burst reads (priority) vs host single writes,
// with a starvation limit. Optional statistics counters under FB_ARB_STATS_EN.
module fb_mem_arbiter #(
   parameter int AW         = 20,
   parameter int DW         = 16,
   parameter int BURST      = 8,
   parameter int STARVE_LIM = 4
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_addr,
   output logic          disp_gnt,
   output logic [DW-1:0] disp_rdata,
   output logic          disp_rvalid,
   input  logic          host_req,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ready,
   input  logic          mem_rvalid,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
`ifdef FB_ARB_STATS_EN
   output logic [15:0]   stat_host_stall,
   output logic [15:0]   stat_bursts,
`endif
   output logic [1:0]    dbg_state
);

   localparam int CW = $clog2(BURST + 1);
   localparam int SW = $clog2(STARVE_LIM + 1);
   localparam logic [CW-1:0] BURST_C  = CW'(BURST);
   localparam logic [CW-1:0] LAST_C   = CW'(BURST - 1);
   localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIM);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DISP_CMD  = 2'd1,
      DISP_WAIT = 2'd2,
      HOST_CMD  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] base_q, base_d;
   logic [CW-1:0] cmd_cnt_q, cmd_cnt_d;
   logic [CW-1:0] rd_cnt_q, rd_cnt_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          disp_gnt_q, disp_gnt_d;
   logic          host_gnt_q, host_gnt_d;
   logic          disp_rvalid_q, disp_rvalid_d;
   logic [DW-1:0] disp_rdata_q, disp_rdata_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          busy_q, busy_d;

   logic          disp_win;
   logic          rd_phase;
   logic [CW-1:0] cmd_nxt;

   // Memory command handshake: a command transfers on a cycle where mem_req & mem_ready;
   // once raised, mem_req and its addr/we/wdata hold unchanged until that transfer.
   assign disp_win = disp_req & (~host_req | (starve_q < STARVE_C));
   assign rd_phase = (state_q == DISP_CMD) || (state_q == DISP_WAIT);
   assign cmd_nxt  = cmd_cnt_q + CW'(1);

   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      cmd_cnt_d     = cmd_cnt_q;
      rd_cnt_d      = rd_cnt_q;
      starve_d      = starve_q;
      disp_gnt_d    = 1'b0;
      host_gnt_d    = 1'b0;
      disp_rvalid_d = 1'b0;
      disp_rdata_d  = disp_rdata_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;

      case (state_q)
         IDLE: begin
            if (disp_win) begin
               state_d    = DISP_CMD;
               base_d     = disp_addr;
               cmd_cnt_d  = '0;
               rd_cnt_d   = '0;
               disp_gnt_d = 1'b1;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = disp_addr;
               if (host_req && (starve_q != STARVE_C)) begin
                  starve_d = starve_q + SW'(1);
               end
            end else if (host_req) begin
               state_d     = HOST_CMD;
               host_gnt_d  = 1'b1;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = host_addr;
               mem_wdata_d = host_wdata;
               starve_d    = '0;
            end
         end
         DISP_CMD: begin
            if (mem_ready) begin
               cmd_cnt_d = cmd_nxt;
               if (cmd_cnt_q == LAST_C) begin
                  state_d   = DISP_WAIT;
                  mem_req_d = 1'b0;
               end else begin
                  mem_addr_d = base_q + AW'(cmd_nxt);
               end
            end
         end
         DISP_WAIT: begin
            if (rd_cnt_q == BURST_C) begin
               state_d = IDLE;
            end
         end
         HOST_CMD: begin
            if (mem_ready) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Returns outside a burst, or beyond its BURST words, are stale and dropped.
      if (rd_phase && mem_rvalid && (rd_cnt_q != BURST_C)) begin
         rd_cnt_d      = rd_cnt_q + CW'(1);
         disp_rvalid_d = 1'b1;
         disp_rdata_d  = mem_rdata;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q       <= IDLE;
         base_q        <= '0;
         cmd_cnt_q     <= '0;
         rd_cnt_q      <= '0;
         starve_q      <= '0;
         disp_gnt_q    <= 1'b0;
         host_gnt_q    <= 1'b0;
         disp_rvalid_q <= 1'b0;
         disp_rdata_q  <= '0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         base_q        <= base_d;
         cmd_cnt_q     <= cmd_cnt_d;
         rd_cnt_q      <= rd_cnt_d;
         starve_q      <= starve_d;
         disp_gnt_q    <= disp_gnt_d;
         host_gnt_q    <= host_gnt_d;
         disp_rvalid_q <= disp_rvalid_d;
         disp_rdata_q  <= disp_rdata_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         busy_q        <= busy_d;
      end
   end

   assign disp_gnt    = disp_gnt_q;
   assign host_gnt    = host_gnt_q;
   assign disp_rvalid = disp_rvalid_q;
   assign disp_rdata  = disp_rdata_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign busy        = busy_q;
   assign dbg_state   = state_q;

`ifdef FB_ARB_STATS_EN
   logic [15:0] stall_q, stall_d;
   logic [15:0] bursts_q, bursts_d;

   always_comb begin
      stall_d  = stall_q;
      bursts_d = bursts_q;
      if (host_req && !host_gnt_q && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
      if (disp_gnt_d) begin
         bursts_d = bursts_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         stall_q  <= '0;
         bursts_q <= '0;
      end else begin
         stall_q  <= stall_d;
         bursts_q <= bursts_d;
      end
   end

   assign stat_host_stall = stall_q;
   assign stat_bursts     = bursts_q;
`endif

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Bench for fb_mem_arbiter: memory responder, transaction-level expected queues
// checked every cycle, and directed scenarios with literal timing/address checks.
module tb_fb_mem_arbiter;
   localparam int AW = 20;
   localparam int DW = 16;
   localparam int NB = 8;

   logic          clk = 1'b0;
   logic          nrst = 1'b1;
   logic          disp_req = 1'b0;
   logic [AW-1:0] disp_addr = '0;
   logic          disp_gnt;
   logic [DW-1:0] disp_rdata;
   logic          disp_rvalid;
   logic          host_req = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wdata = '0;
   logic          host_gnt;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready = 1'b1;
   logic          mem_rvalid = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          busy;
   logic [1:0]    dbg_state;
`ifdef FB_ARB_STATS_EN
   logic [15:0]   stat_host_stall;
   logic [15:0]   stat_bursts;
`endif

   fb_mem_arbiter dut (
      .clk(clk), .nrst(nrst),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
      .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
      .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .busy(busy),
`ifdef FB_ARB_STATS_EN
      .stat_host_stall(stat_host_stall), .stat_bursts(stat_bursts),
`endif
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int rd_lat = 2;
   int stall_cnt = 0;
   bit ready_mode = 1'b0;
   bit ready_tog = 1'b0;

   logic [AW-1:0]    pend_a[$];
   int               pend_due[$];
   logic [AW-1:0]    acc_log[$];
   logic [AW+DW:0]   exp_cmd_q[$];
   logic [DW-1:0]    exp_rd_q[$];
   logic [1:0]       exp_gnt_q[$];

   function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
      return a[15:0] ^ 16'h5A3C;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm, input logic [63:0] act);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %0h expected nothing", nm, act);
   endtask

   // scoreboard model: transaction order and data, independent of FSM timing
   task automatic push_burst(input logic [AW-1:0] a);
      logic [AW-1:0] x;
      for (int i = 0; i < NB; i++) begin
         x = a + AW'(i);
         exp_cmd_q.push_back({1'b0, x, 16'h0000});
         exp_rd_q.push_back(fdat(x));
      end
      exp_gnt_q.push_back(2'b01);
   endtask

   task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_cmd_q.push_back({1'b1, a, d});
      exp_gnt_q.push_back(2'b10);
   endtask

   // memory responder: in-order read returns after rd_lat cycles, optional ready toggling
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         mem_rvalid = 1'b0;
         mem_rdata  = 16'hDEAD;
         if (pend_a.size() != 0 && pend_due[0] <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = fdat(pend_a.pop_front());
            void'(pend_due.pop_front());
         end
         ready_tog = ~ready_tog;
         mem_ready = ready_mode ? ready_tog : 1'b1;
      end
   end

   // compare process
   logic          prev_stall = 1'b0, prev_dg = 1'b0, prev_hg = 1'b0, prev_we = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [DW-1:0] prev_wdata = '0;
   always @(negedge clk) begin
      if (!nrst) begin
         prev_stall = 1'b0;
         prev_dg    = 1'b0;
         prev_hg    = 1'b0;
      end else begin
         if (prev_stall)
            chk("cmd_hold", 64'({mem_req, mem_we, mem_addr, mem_wdata}),
                64'({1'b1, prev_we, prev_addr, prev_wdata}));
         if (mem_req && mem_ready) begin
            if (exp_cmd_q.size() == 0)
               unexpected("cmd_unexpected", 64'({mem_we, mem_addr}));
            else
               chk("mem_cmd", 64'({mem_we, mem_addr, (mem_we ? mem_wdata : 16'h0000)}),
                   64'(exp_cmd_q.pop_front()));
            if (!mem_we) begin
               acc_log.push_back(mem_addr);
               pend_a.push_back(mem_addr);
               pend_due.push_back(cyc + rd_lat);
            end
         end
         if (mem_req && !mem_ready) stall_cnt++;
         if (disp_rvalid) begin
            if (exp_rd_q.size() == 0) unexpected("rvalid_unexpected", 64'(disp_rdata));
            else chk("disp_rdata", 64'(disp_rdata), 64'(exp_rd_q.pop_front()));
         end
         if (disp_gnt || host_gnt) begin
            if (exp_gnt_q.size() == 0) unexpected("gnt_unexpected", 64'({host_gnt, disp_gnt}));
            else chk("grant", 64'({host_gnt, disp_gnt}), 64'(exp_gnt_q.pop_front()));
         end
         if (prev_dg) chk("disp_gnt_pulse", 64'(disp_gnt), 64'(0));
         if (prev_hg) chk("host_gnt_pulse", 64'(host_gnt), 64'(0));
         if (mem_req) chk("busy_with_req", 64'(busy), 64'(1));
         prev_stall = mem_req && !mem_ready;
         prev_we    = mem_we;
         prev_addr  = mem_addr;
         prev_wdata = mem_wdata;
         prev_dg    = disp_gnt;
         prev_hg    = host_gnt;
      end
   end

   // driver tasks
   task automatic disp_burst(input logic [AW-1:0] a);
      bit got = 1'b0;
      disp_addr = a;
      disp_req  = 1'b1;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (disp_gnt) got = 1'b1;
      end
      disp_req  = 1'b0;
      disp_addr = ~a;
      chk("disp_gnt_seen", 64'(got), 64'(1));
   endtask

   task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit got = 1'b0;
      host_addr  = a;
      host_wdata = d;
      host_req   = 1'b1;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (host_gnt) got = 1'b1;
      end
      host_req   = 1'b0;
      host_addr  = ~a;
      host_wdata = ~d;
      chk("host_gnt_seen", 64'(got), 64'(1));
   endtask

   task automatic wait_idle(input string nm);
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (!busy && pend_a.size() == 0 && exp_rd_q.size() == 0 && exp_cmd_q.size() == 0)
            done = 1'b1;
      end
      chk(nm, 64'(done), 64'(1));
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_disp_gnt"},    64'(disp_gnt), 64'(0));
      chk({nm, "_disp_rvalid"}, 64'(disp_rvalid), 64'(0));
      chk({nm, "_disp_rdata"},  64'(disp_rdata), 64'(0));
      chk({nm, "_host_gnt"},    64'(host_gnt), 64'(0));
      chk({nm, "_mem_req"},     64'(mem_req), 64'(0));
      chk({nm, "_mem_we"},      64'(mem_we), 64'(0));
      chk({nm, "_mem_addr"},    64'(mem_addr), 64'(0));
      chk({nm, "_mem_wdata"},   64'(mem_wdata), 64'(0));
      chk({nm, "_busy"},        64'(busy), 64'(0));
      chk({nm, "_dbg_state"},   64'(dbg_state), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   logic [AW-1:0] wrap_tab [8];
   int first_req, rv_n, last_rv, idle_c, hg_c, n_acc;
   bit seen;

   initial begin
      wrap_tab = '{20'hFFFFC, 20'hFFFFD, 20'hFFFFE, 20'hFFFFF,
                   20'h00000, 20'h00001, 20'h00002, 20'h00003};
      #2 nrst = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("rst");
      nrst = 1'b1;

      // 1: display only, literal address sequence and busy drop
      push_burst(20'h00100);
      @(negedge clk);
      disp_addr = 20'h00100;
      disp_req  = 1'b1;
      first_req = -1; rv_n = 0; last_rv = -1; idle_c = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (disp_gnt) disp_req = 1'b0;
         if (mem_req && first_req < 0) first_req = cyc;
         if (first_req >= 0 && (cyc - first_req) < NB)
            chk("t1_addr", 64'({mem_req, mem_addr}),
                64'({1'b1, 20'h00100 + 20'(cyc - first_req)}));
         if (disp_rvalid) begin
            rv_n++;
            last_rv = cyc;
         end
         if (first_req >= 0 && !busy && idle_c < 0) idle_c = cyc;
      end
      chk("t1_rv_count", 64'(rv_n), 64'(8));
      chk("t1_busy_drop", 64'(idle_c), 64'(last_rv + 1));
      wait_idle("t1_idle");

      // 2: simultaneous requests, display first, host two cycles after burst ends
      push_burst(20'h00200);
      push_write(20'h00300, 16'hBEEF);
      @(negedge clk);
      seen = 1'b0; idle_c = -1; hg_c = -1;
      fork
         disp_burst(20'h00200);
         host_write(20'h00300, 16'hBEEF);
         begin
            for (int i = 0; i < 80; i++) begin
               @(negedge clk);
               if (disp_gnt) seen = 1'b1;
               if (seen && !busy && idle_c < 0) idle_c = cyc;
               if (host_gnt && hg_c < 0) hg_c = cyc;
            end
         end
      join
      chk("t2_host_slot", 64'(hg_c), 64'(idle_c + 1));
      wait_idle("t2_idle");

      // 3: starvation limit, latency 1
      rd_lat = 1;
      for (int k = 0; k < 4; k++) push_burst(20'h04000 + 20'(k * 64));
      push_write(20'h05000, 16'h1111);
      for (int k = 4; k < 8; k++) push_burst(20'h04000 + 20'(k * 64));
      push_write(20'h05001, 16'h2222);
      @(negedge clk);
      fork
         begin
            for (int k = 0; k < 8; k++) disp_burst(20'h04000 + 20'(k * 64));
         end
         begin
            host_write(20'h05000, 16'h1111);
            host_write(20'h05001, 16'h2222);
         end
      join
      wait_idle("t3_idle");

      // 4: address wrap
      rd_lat = 2;
      acc_log.delete();
      push_burst(20'hFFFFC);
      disp_burst(20'hFFFFC);
      wait_idle("t4_idle");
      chk("t4_count", 64'(acc_log.size()), 64'(8));
      for (int i = 0; i < 8 && i < acc_log.size(); i++)
         chk("t4_wrap", 64'(acc_log[i]), 64'(wrap_tab[i]));

      // 5: toggling mem_ready during burst and host write
      rd_lat = 4;
      acc_log.delete();
      stall_cnt = 0;
      ready_mode = 1'b1;
      push_burst(20'h00800);
      push_write(20'h00900, 16'hCAFE);
      disp_burst(20'h00800);
      host_write(20'h00900, 16'hCAFE);
      wait_idle("t5_idle");
      ready_mode = 1'b0;
      chk("t5_reads", 64'(acc_log.size()), 64'(8));
      chk("t5_stalls_seen", 64'(stall_cnt != 0), 64'(1));

      // 6: async reset mid-burst, stale returns dropped, then normal service
      rd_lat = 3;
      push_burst(20'h00C00);
      @(negedge clk);
      disp_addr = 20'h00C00;
      disp_req  = 1'b1;
      n_acc = 0;
      for (int i = 0; i < 100 && n_acc < 3; i++) begin
         @(negedge clk);
         if (disp_gnt) disp_req = 1'b0;
         if (mem_req && mem_ready) n_acc++;
      end
      chk("t6_accepts", 64'(n_acc), 64'(3));
      @(posedge clk);
      #3 nrst = 1'b0;
      #1 check_zero("t6_rst");
      disp_req = 1'b0;
      exp_cmd_q.delete();
      exp_rd_q.delete();
      exp_gnt_q.delete();
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      for (int i = 0; i < 50 && pend_a.size() != 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("t6_stale_drained", 64'(pend_a.size()), 64'(0));
      rd_lat = 2;
      push_burst(20'h00A00);
      disp_burst(20'h00A00);
      wait_idle("t6_idle");

      chk("end_cmd_q", 64'(exp_cmd_q.size()), 64'(0));
      chk("end_rd_q", 64'(exp_rd_q.size()), 64'(0));
      chk("end_gnt_q", 64'(exp_gnt_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
